// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU control codes and the instruction class latched in DECODE.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      CLS_NONE   = 3'd0,
      CLS_LOAD   = 3'd1,
      CLS_STORE  = 3'd2,
      CLS_OPIMM  = 3'd3,
      CLS_OP     = 3'd4,
      CLS_BRANCH = 3'd5
   } class_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   function automatic class_e opcode_class(input logic [6:0] opc);
      case (opc)
         OPC_LOAD:   return CLS_LOAD;
         OPC_STORE:  return CLS_STORE;
         OPC_OPIMM:  return CLS_OPIMM;
         OPC_OP:     return CLS_OP;
         OPC_BRANCH: return CLS_BRANCH;
         default:    return CLS_NONE;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-operation decode: maps the instruction class plus funct
// fields to an ALU control code and a legality flag.
module alu_decoder
   import ctrl_pkg::*;
(
   input  class_e     cls_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7_5_i,
   output logic [3:0] alu_o,
   output logic       legal_o
);

   always_comb begin
      alu_o   = ALU_ADD;
      legal_o = 1'b0;
      case (cls_i)
         CLS_LOAD, CLS_STORE: legal_o = 1'b1;
         CLS_OPIMM:           legal_o = (funct3_i == 3'b000);
         CLS_BRANCH: begin
            alu_o   = ALU_SUB;
            legal_o = (funct3_i == 3'b000) || (funct3_i == 3'b001);
         end
         CLS_OP: begin
            // funct7[5] only distinguishes add/sub and rejects sra
            legal_o = 1'b1;
            case (funct3_i)
               3'b000:  alu_o = funct7_5_i ? ALU_SUB : ALU_ADD;
               3'b100:  alu_o = ALU_XOR;
               3'b101: begin
                  alu_o   = ALU_SRL;
                  legal_o = ~funct7_5_i;
               end
               3'b110:  alu_o = ALU_OR;
               3'b111:  alu_o = ALU_AND;
               default: legal_o = 1'b0;
            endcase
         end
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath enables per phase, and traps on illegal instructions or memory timeout.
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int ALUCTRL_W   = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int STATE_W     = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic                 funct7_5,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 pcwrite,
   output logic                 irwrite,
   output logic                 regwrite,
   output logic                 memread,
   output logic                 memwrite,
   output logic                 alusrc,
   output logic                 memtoreg,
   output logic                 pcsrc,
   output logic [ALUCTRL_W-1:0] alucontrol,
   output logic                 illegal,
   output logic                 bus_err,
   output logic [STATE_W-1:0]   dbg_state
);

   localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

   state_e     state_q, state_d;
   class_e     cls_q, cls_d;
   logic [3:0] alu_q, alu_d;
   logic       bne_q, bne_d;
   logic [7:0] cnt_q, cnt_d;
   logic       illegal_q, illegal_d;
   logic       bus_err_q, bus_err_d;

   class_e     dec_cls;
   logic [3:0] dec_alu;
   logic       dec_legal;
   logic [3:0] alu_sel;

   assign dec_cls = opcode_class(opcode);

   alu_decoder u_alu_decoder (
      .cls_i      (dec_cls),
      .funct3_i   (funct3),
      .funct7_5_i (funct7_5),
      .alu_o      (dec_alu),
      .legal_o    (dec_legal)
   );

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      alu_d     = alu_q;
      bne_d     = bne_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
            cnt_d   = 8'd0;
         end
         // A ready arriving on the cycle the count reaches the limit still completes.
         S_FETCH: begin
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (cnt_q == TMO) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_DECODE: begin
            cls_d = dec_cls;
            alu_d = dec_alu;
            bne_d = funct3[0];
            if (dec_legal) begin
               state_d = S_EXEC;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_TRAP;
            end
         end
         S_EXEC: begin
            cnt_d = 8'd0;
            case (cls_q)
               CLS_LOAD, CLS_STORE: state_d = S_MEM;
               CLS_OP, CLS_OPIMM:   state_d = S_WB;
               default:             state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               state_d = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
               cnt_d   = 8'd0;
            end else if (cnt_q == TMO) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            cnt_d   = 8'd0;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cls_q     <= CLS_NONE;
         alu_q     <= 4'd0;
         bne_q     <= 1'b0;
         cnt_q     <= 8'd0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         alu_q     <= alu_d;
         bne_q     <= bne_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Moore decode; FETCH handshake and branch pcwrite look at live inputs.
   always_comb begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      alusrc   = 1'b0;
      memtoreg = 1'b0;
      pcsrc    = 1'b0;
      alu_sel  = 4'd0;
      case (state_q)
         S_FETCH: begin
            memread = 1'b1;
            alusrc  = 1'b1;
            alu_sel = ALU_ADD;
            irwrite = mem_ready;
            pcwrite = mem_ready;
         end
         S_EXEC: begin
            alu_sel = alu_q;
            case (cls_q)
               CLS_OP: alusrc = 1'b0;
               CLS_BRANCH: begin
                  pcsrc   = 1'b1;
                  pcwrite = bne_q ? ~zero : zero;
               end
               default: alusrc = 1'b1;
            endcase
         end
         S_MEM: begin
            memread  = (cls_q == CLS_LOAD);
            memwrite = (cls_q == CLS_STORE);
         end
         S_WB: begin
            regwrite = 1'b1;
            memtoreg = (cls_q == CLS_LOAD);
         end
         default: ;
      endcase
   end

   assign alucontrol = ALUCTRL_W'(alu_sel);
   assign illegal    = illegal_q;
   assign bus_err    = bus_err_q;
   assign dbg_state  = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-instruction phase model builds the
// expected cycle-by-cycle outputs, which are compared against the DUT every cycle.
module tb_multicycle_control;

   localparam int TMO = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       funct7_5 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pcwrite, irwrite, regwrite, memread, memwrite, alusrc, memtoreg, pcsrc;
   logic [3:0] alucontrol;
   logic       illegal, bus_err;
   logic [2:0] dbg_state;

   multicycle_control #(.ALUCTRL_W(4), .MEM_TIMEOUT(TMO), .STATE_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .irwrite(irwrite),
      .regwrite(regwrite), .memread(memread), .memwrite(memwrite), .alusrc(alusrc),
      .memtoreg(memtoreg), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal),
      .bus_err(bus_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Phase numbers follow the listed state order IDLE..TRAP.
   localparam logic [2:0] P_IDLE = 3'd0, P_FETCH = 3'd1, P_DECODE = 3'd2, P_EXEC = 3'd3,
                          P_MEM = 3'd4, P_WB = 3'd5, P_TRAP = 3'd6;

   typedef struct packed {
      logic [6:0] opc;
      logic [2:0] f3;
      logic       f7, zero, rdy;
      logic       pcw, irw, rw, mr, mw, as, mtr, pcs;
      logic [3:0] alu;
      logic       ill, be;
      logic [2:0] st;
   } rec_t;

   rec_t       q[$];
   logic       m_ill, m_be;
   logic [6:0] cur_opc;
   logic [2:0] cur_f3;
   logic       cur_f7, cur_zero;
   int         passed = 0;
   int         total = 0;
   int         mr_cnt;
   string      tag;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic rec_t mk(input logic [2:0] st, input logic rdy);
      rec_t r;
      r      = '0;
      r.opc  = cur_opc;
      r.f3   = cur_f3;
      r.f7   = cur_f7;
      r.zero = cur_zero;
      r.rdy  = rdy;
      r.st   = st;
      r.ill  = m_ill;
      r.be   = m_be;
      return r;
   endfunction

   // ALU operation and legality straight from the instruction table.
   task automatic spec_decode(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                              output logic [3:0] a, output logic ok);
      a  = 4'b0010;
      ok = 1'b0;
      if (opc == 7'b0000011 || opc == 7'b0100011) ok = 1'b1;
      else if (opc == 7'b0010011) ok = (f3 == 3'd0);
      else if (opc == 7'b1100011) begin a = 4'b0110; ok = (f3 <= 3'd1); end
      else if (opc == 7'b0110011) begin
         ok = 1'b1;
         if (f3 == 3'd0)                 a = f7 ? 4'b0110 : 4'b0010;
         else if (f3 == 3'd4)            a = 4'b0011;
         else if (f3 == 3'd5 && !f7)     a = 4'b0101;
         else if (f3 == 3'd6)            a = 4'b0001;
         else if (f3 == 3'd7)            a = 4'b0000;
         else                            ok = 1'b0;
      end
   endtask

   task automatic trap_cycles();
      for (int i = 0; i < 3; i++) q.push_back(mk(P_TRAP, 1'b0));
   endtask

   // Builds the expected cycles of one instruction given its wait-state profile.
   task automatic expand(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic z, input int fwait, input int mwait);
      rec_t r;
      logic [3:0] a;
      logic ok, ld, sw, br, op;
      cur_opc = opc; cur_f3 = f3; cur_f7 = f7; cur_zero = z;
      for (int i = 0; i < fwait && i <= TMO; i++) begin
         r = mk(P_FETCH, 1'b0); r.mr = 1; r.as = 1; r.alu = 4'b0010; q.push_back(r);
      end
      if (fwait > TMO) begin m_be = 1'b1; trap_cycles(); return; end
      r = mk(P_FETCH, 1'b1); r.mr = 1; r.as = 1; r.alu = 4'b0010; r.irw = 1; r.pcw = 1;
      q.push_back(r);
      q.push_back(mk(P_DECODE, 1'b1));
      spec_decode(opc, f3, f7, a, ok);
      if (!ok) begin m_ill = 1'b1; trap_cycles(); return; end
      ld = (opc == 7'b0000011); sw = (opc == 7'b0100011);
      br = (opc == 7'b1100011); op = (opc == 7'b0110011);
      r = mk(P_EXEC, 1'b1); r.alu = a; r.as = !(op || br);
      if (br) begin r.pcs = 1; r.pcw = f3[0] ? !z : z; end
      q.push_back(r);
      if (br) return;
      if (ld || sw) begin
         for (int i = 0; i < mwait && i <= TMO; i++) begin
            r = mk(P_MEM, 1'b0); r.mr = ld; r.mw = sw; q.push_back(r);
         end
         if (mwait > TMO) begin m_be = 1'b1; trap_cycles(); return; end
         r = mk(P_MEM, 1'b1); r.mr = ld; r.mw = sw; q.push_back(r);
         if (sw) return;
      end
      r = mk(P_WB, 1'b1); r.rw = 1; r.mtr = ld; q.push_back(r);
   endtask

   task automatic compare(input rec_t r, input int idx);
      string p;
      p = $sformatf("%s.c%0d", tag, idx);
      check({p, ".pcwrite"},    pcwrite,    r.pcw);
      check({p, ".irwrite"},    irwrite,    r.irw);
      check({p, ".regwrite"},   regwrite,   r.rw);
      check({p, ".memread"},    memread,    r.mr);
      check({p, ".memwrite"},   memwrite,   r.mw);
      check({p, ".alusrc"},     alusrc,     r.as);
      check({p, ".memtoreg"},   memtoreg,   r.mtr);
      check({p, ".pcsrc"},      pcsrc,      r.pcs);
      check({p, ".alucontrol"}, alucontrol, r.alu);
      check({p, ".illegal"},    illegal,    r.ill);
      check({p, ".bus_err"},    bus_err,    r.be);
      check({p, ".dbg_state"},  dbg_state,  r.st);
   endtask

   task automatic run_queue(input int limit);
      rec_t r;
      int n;
      n = 0;
      while (q.size() > 0 && n < limit) begin
         r = q.pop_front();
         @(posedge clk);
         #1;
         opcode = r.opc; funct3 = r.f3; funct7_5 = r.f7; zero = r.zero; mem_ready = r.rdy;
         @(negedge clk);
         if (memread) mr_cnt++;
         compare(r, n);
         n++;
      end
      q.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m_ill = 1'b0;
      m_be  = 1'b0;
      q.delete();
      #1;
      check("reset_outs_now", {pcwrite, irwrite, regwrite, memread, memwrite, alusrc, memtoreg,
                               pcsrc, alucontrol, illegal, bus_err, dbg_state}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("idle_outs", {pcwrite, irwrite, regwrite, memread, memwrite, alusrc, memtoreg,
                          pcsrc, alucontrol, illegal, bus_err, dbg_state}, 32'd0);
   endtask

   typedef struct packed { logic [6:0] opc; logic [2:0] f3; logic f7; } ins_t;
   ins_t alu_tbl[7];

   initial begin
      rst_n = 1'b1;
      #1;
      do_reset();

      tag = "add";
      expand(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
      check("lat_add", q.size(), 4);
      run_queue(100);

      alu_tbl[0] = '{7'b0110011, 3'b000, 1'b1};
      alu_tbl[1] = '{7'b0110011, 3'b100, 1'b0};
      alu_tbl[2] = '{7'b0110011, 3'b101, 1'b0};
      alu_tbl[3] = '{7'b0110011, 3'b110, 1'b0};
      alu_tbl[4] = '{7'b0110011, 3'b111, 1'b0};
      alu_tbl[5] = '{7'b0010011, 3'b000, 1'b0};
      alu_tbl[6] = '{7'b0100011, 3'b010, 1'b0};
      for (int i = 0; i < 7; i++) begin
         tag = $sformatf("alu%0d", i);
         expand(alu_tbl[i].opc, alu_tbl[i].f3, alu_tbl[i].f7, 1'b0, 0, 0);
         check({tag, ".lat"}, q.size(), 4);
         run_queue(100);
      end

      for (int i = 0; i < 4; i++) begin
         tag = $sformatf("br%0d", i);
         expand(7'b1100011, 3'(i % 2), 1'b0, (i < 2), 0, 0);
         check({tag, ".lat"}, q.size(), 3);
         run_queue(100);
      end

      tag = "lw0";
      expand(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0);
      check("lat_lw", q.size(), 5);
      run_queue(100);

      tag = "lw_wait";
      mr_cnt = 0;
      expand(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
      check("lat_lw_wait", q.size(), 8);
      run_queue(100);
      check("lw_wait.memread_cycles", mr_cnt, 5);

      tag = "fetch_at_limit";
      expand(7'b0110011, 3'b000, 1'b0, 1'b0, TMO, 0);
      run_queue(100);
      check("fetch_at_limit.bus_err", bus_err, 1'b0);

      tag = "lw_at_limit";
      expand(7'b0000011, 3'b010, 1'b0, 1'b0, 0, TMO);
      run_queue(100);

      tag = "mid_mem";
      expand(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
      run_queue(5);
      check("mid_mem.memread_before", memread, 1'b1);
      do_reset();

      tag = "after_reset";
      expand(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
      run_queue(100);

      tag = "ill_opc";
      expand(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
      run_queue(100);
      check("ill_opc.illegal", illegal, 1'b1);
      check("ill_opc.state", dbg_state, 3'd6);
      do_reset();

      tag = "ill_sra";
      expand(7'b0110011, 3'b101, 1'b1, 1'b0, 0, 0);
      run_queue(100);
      do_reset();

      tag = "fetch_tmo";
      expand(7'b0110011, 3'b000, 1'b0, 1'b0, TMO + 1, 0);
      run_queue(100);
      check("fetch_tmo.bus_err", bus_err, 1'b1);
      do_reset();

      tag = "sw_tmo";
      expand(7'b0100011, 3'b010, 1'b0, 1'b0, 0, TMO + 1);
      run_queue(100);
      check("sw_tmo.memwrite_off", memwrite, 1'b0);
      do_reset();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
